w5300_bus_ctrl: RTL

W5300_BUS_CTRL -- requirements
Module: w5300_bus_ctrl

---
 rtl/w5300_bus_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/w5300_bus_ctrl.sv
// w5300_bus_ctrl
// Bus-cycle sequencer for the W5300 parallel host interface. Each request is
// latched in Idle and then walks through Setup -> Strobe -> Hold -> Recover.
// The phase lengths are parameters, and a zero parameter is treated as one
// cycle. Every pin output is a register that is loaded from the next-state
// decode, so no input reaches an output through combinational logic.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   enable          request valid (sampled only in Idle)
//   addr[10:0]      bit10 = 1 write / 0 read, bits[9:0] = register address
//   wr_data[15:0]   write data
//   rd_data[15:0]   last captured read data
//   op_state        one-cycle completion pulse (first Recover cycle)
//   busy            high in every non-Idle state
//   w5300_cs_n/rd_n/wr_n  active-low chip select and strobes
//   w5300_addr[9:0] address pins
//   w5300_dout/doe  data bus drive value and output enable
//   w5300_din       data bus sampled value
module w5300_bus_ctrl #(
    parameter logic [3:0] SETUP_CYC   = 4'd1,
    parameter logic [3:0] STROBE_CYC  = 4'd7,
    parameter logic [3:0] HOLD_CYC    = 4'd1,
    parameter logic [3:0] RECOVER_CYC = 4'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [10:0] addr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        op_state,
    output logic        busy,
    output logic        w5300_cs_n,
    output logic        w5300_rd_n,
    output logic        w5300_wr_n,
    output logic [9:0]  w5300_addr,
    output logic [15:0] w5300_dout,
    output logic        w5300_doe,
    input  logic [15:0] w5300_din
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_STROBE  = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_RECOVER = 3'd4;

    // Phase length with zero promoted to one cycle.
    function automatic logic [3:0] eff_cyc(input logic [3:0] p);
        eff_cyc = (p == 4'd0) ? 4'd1 : p;
    endfunction

    logic [2:0] state_r;
    logic [2:0] state_nxt_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_nxt_s;
    logic       is_wr_r;
    logic       wr_nxt_s;
    logic       active_nxt_s;
    logic       last_s;

    // The phase ends on its final counted cycle.
    assign last_s = (cnt_r <= 4'd1);

    // Direction of the access that the next state belongs to. In Idle this is
    // the incoming request, otherwise the latched one.
    assign wr_nxt_s = (state_r == ST_IDLE) ? addr[10] : is_wr_r;

    assign active_nxt_s = (state_nxt_s == ST_SETUP) || (state_nxt_s == ST_STROBE) ||
                          (state_nxt_s == ST_HOLD);

    // Next-state and phase-counter decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = (cnt_r != 4'd0) ? (cnt_r - 4'd1) : 4'd0;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt_s = ST_SETUP;
                    cnt_nxt_s   = eff_cyc(SETUP_CYC);
                end else begin
                    cnt_nxt_s   = 4'd0;
                end
            end
            ST_SETUP: begin
                if (last_s) begin
                    state_nxt_s = ST_STROBE;
                    cnt_nxt_s   = eff_cyc(STROBE_CYC);
                end else begin
                    state_nxt_s = ST_SETUP;
                end
            end
            ST_STROBE: begin
                if (last_s) begin
                    state_nxt_s = ST_HOLD;
                    cnt_nxt_s   = eff_cyc(HOLD_CYC);
                end else begin
                    state_nxt_s = ST_STROBE;
                end
            end
            ST_HOLD: begin
                if (last_s) begin
                    state_nxt_s = ST_RECOVER;
                    cnt_nxt_s   = eff_cyc(RECOVER_CYC);
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_RECOVER: begin
                if (last_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 4'd0;
                end else begin
                    state_nxt_s = ST_RECOVER;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // State register and phase counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Request latch: captured only when Idle accepts a request, so later
    // changes on enable/addr/wr_data cannot disturb the access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_wr_r    <= 1'b0;
            w5300_addr <= 10'd0;
            w5300_dout <= 16'd0;
        end else if ((state_r == ST_IDLE) && enable) begin
            is_wr_r    <= addr[10];
            w5300_addr <= addr[9:0];
            w5300_dout <= wr_data;
        end else begin
            is_wr_r    <= is_wr_r;
            w5300_addr <= w5300_addr;
            w5300_dout <= w5300_dout;
        end
    end

    // Registered pin controls and status, decoded from the next state.
    // doe only follows writes and rd_n only follows reads, so they never overlap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w5300_cs_n <= 1'b1;
            w5300_rd_n <= 1'b1;
            w5300_wr_n <= 1'b1;
            w5300_doe  <= 1'b0;
            op_state   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            w5300_cs_n <= ~active_nxt_s;
            w5300_rd_n <= ~((state_nxt_s == ST_STROBE) && !wr_nxt_s);
            w5300_wr_n <= ~((state_nxt_s == ST_STROBE) && wr_nxt_s);
            w5300_doe  <= active_nxt_s && wr_nxt_s;
            op_state   <= (state_r == ST_HOLD) && (state_nxt_s == ST_RECOVER);
            busy       <= (state_nxt_s != ST_IDLE);
        end
    end

    // Read capture on the edge that ends the last Strobe cycle, while rd_n is
    // still low at the pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= 16'd0;
        end else if ((state_r == ST_STROBE) && last_s && !is_wr_r) begin
            rd_data <= w5300_din;
        end else begin
            rd_data <= rd_data;
        end
    end

endmodule
